// File: rtl/maxpool_window_sched.sv
// maxpool_window_sched: streams a row-major feature-map RAM to the
// max-pooling datapath in pooling-window order (all K x K elements of a
// window back to back), tagging last-of-window and last-of-frame.
//
// Optional feature: define MAXPOOL_SCHED_ABORT_EN to add the abort input,
// which drops any frame in progress and returns to IDLE.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   start            begin one frame (sampled only in IDLE)
//   abort            (MAXPOOL_SCHED_ABORT_EN only) cancel the frame in progress
//   busy             high whenever the scheduler is not IDLE
//   done             one-cycle pulse after the final element handshake
//   ram_en/ram_addr  synchronous-read RAM request
//   ram_rd           RAM read data, valid one cycle after ram_en
//   out_data/out_valid/out_ready         element stream to the datapath
//   out_last_win/out_last_frame          element tags
module maxpool_window_sched #(
  parameter int unsigned H  = 6,
  parameter int unsigned W  = 6,
  parameter int unsigned K  = 2,
  parameter int unsigned S  = 2,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
`ifdef MAXPOOL_SCHED_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          done,
  output logic          ram_en,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_rd,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last_win,
  output logic          out_last_frame
);

  localparam int unsigned OH  = (H - K) / S + 1;
  localparam int unsigned OW  = (W - K) / S + 1;
  localparam int unsigned OYW = (OH > 1) ? $clog2(OH) : 1;
  localparam int unsigned OXW = (OW > 1) ? $clog2(OW) : 1;
  localparam int unsigned KW  = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [OYW-1:0]   oy_q, oy_d;
  logic [OXW-1:0]   ox_q, ox_d;
  logic [KW-1:0]    ky_q, ky_d;
  logic [KW-1:0]    kx_q, kx_d;

  logic             busy_d, done_d, ram_en_d, out_valid_d;
  logic             last_win_d, last_frame_d;
  logic [AW-1:0]    ram_addr_d;
  logic [DW-1:0]    out_data_d;
  logic             abort_c;
  logic             win_end_c, frame_end_c;

  // Linear RAM address of window element (oy,ox,ky,kx).
  function automatic logic [AW-1:0] elem_addr(input logic [OYW-1:0] oy,
                                              input logic [OXW-1:0] ox,
                                              input logic [KW-1:0]  ky,
                                              input logic [KW-1:0]  kx);
    logic [31:0] row, col;
    row = 32'(oy) * 32'(S) + 32'(ky);
    col = 32'(ox) * 32'(S) + 32'(kx);
    return AW'(row * 32'(W) + col);
  endfunction

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      oy_q           <= '0;
      ox_q           <= '0;
      ky_q           <= '0;
      kx_q           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      ram_en         <= 1'b0;
      ram_addr       <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_last_win   <= 1'b0;
      out_last_frame <= 1'b0;
    end else begin
      state_q        <= state_d;
      oy_q           <= oy_d;
      ox_q           <= ox_d;
      ky_q           <= ky_d;
      kx_q           <= kx_d;
      busy           <= busy_d;
      done           <= done_d;
      ram_en         <= ram_en_d;
      ram_addr       <= ram_addr_d;
      out_data       <= out_data_d;
      out_valid      <= out_valid_d;
      out_last_win   <= last_win_d;
      out_last_frame <= last_frame_d;
    end
  end

  // Next state, counter advance and next output values.
  always_comb begin
    state_d      = state_q;
    oy_d         = oy_q;
    ox_d         = ox_q;
    ky_d         = ky_q;
    kx_d         = kx_q;
    ram_en_d     = 1'b0;
    ram_addr_d   = ram_addr;
    out_data_d   = out_data;
    out_valid_d  = out_valid;
    last_win_d   = out_last_win;
    last_frame_d = out_last_frame;

`ifdef MAXPOOL_SCHED_ABORT_EN
    abort_c = abort;
`else
    abort_c = 1'b0;
`endif

    win_end_c   = (kx_q == KW'(K - 1)) && (ky_q == KW'(K - 1));
    frame_end_c = win_end_c && (ox_q == OXW'(OW - 1)) && (oy_q == OYW'(OH - 1));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_ISSUE;
          oy_d       = '0;
          ox_d       = '0;
          ky_d       = '0;
          kx_d       = '0;
          ram_en_d   = 1'b1;
          ram_addr_d = '0;
        end
      end
      ST_ISSUE: state_d = ST_LOAD;
      ST_LOAD: begin
        out_data_d   = ram_rd;
        out_valid_d  = 1'b1;
        last_win_d   = win_end_c;
        last_frame_d = frame_end_c;
        state_d      = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          // kx -> ky -> ox -> oy carry chain
          if (kx_q == KW'(K - 1)) begin
            kx_d = '0;
            if (ky_q == KW'(K - 1)) begin
              ky_d = '0;
              if (ox_q == OXW'(OW - 1)) begin
                ox_d = '0;
                oy_d = (oy_q == OYW'(OH - 1)) ? '0 : oy_q + OYW'(1);
              end else begin
                ox_d = ox_q + OXW'(1);
              end
            end else begin
              ky_d = ky_q + KW'(1);
            end
          end else begin
            kx_d = kx_q + KW'(1);
          end
          if (frame_end_c) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_ISSUE;
            ram_en_d   = 1'b1;
            ram_addr_d = elem_addr(oy_d, ox_d, ky_d, kx_d);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort beats any handshake in the same cycle; ignored while IDLE.
    if (abort_c && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      oy_d        = '0;
      ox_d        = '0;
      ky_d        = '0;
      kx_d        = '0;
      ram_en_d    = 1'b0;
      ram_addr_d  = ram_addr;
      out_valid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

endmodule

// File: tb/tb_maxpool_window_sched.sv
// Directed self-checking bench for maxpool_window_sched: default 6x6 map
// plus a 5x5 instance, with behavioural synchronous-read RAM models.
module tb_maxpool_window_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, out_ready;
  logic        busy, done, ram_en, out_valid, out_last_win, out_last_frame;
  logic [31:0] ram_addr;
  logic [7:0]  ram_rd, out_data;
`ifdef MAXPOOL_SCHED_ABORT_EN
  logic        abort;
`endif

  logic        s_start, s_out_ready;
  logic        s_busy, s_done, s_ram_en, s_out_valid, s_last_win, s_last_frame;
  logic [31:0] s_ram_addr;
  logic [7:0]  s_ram_rd, s_out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_val(input logic [31:0] a);
    return 8'(a * 32'd5 + 32'd1);
  endfunction

  // Expected address of element idx for K=S=2 on a map of width wd.
  function automatic logic [31:0] exp_addr(input int idx, input int wd);
    int ow, win, e, oy, ox, ky, kx;
    ow  = (wd - 2) / 2 + 1;
    win = idx / 4;
    e   = idx % 4;
    oy  = win / ow;
    ox  = win % ow;
    ky  = e / 2;
    kx  = e % 2;
    return 32'((oy * 2 + ky) * wd + ox * 2 + kx);
  endfunction

  maxpool_window_sched dut (
    .clk(clk), .rstn(rstn), .start(start),
`ifdef MAXPOOL_SCHED_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_rd(ram_rd), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last_win(out_last_win),
    .out_last_frame(out_last_frame)
  );

  maxpool_window_sched #(.H(5), .W(5)) dut5 (
    .clk(clk), .rstn(rstn), .start(s_start),
`ifdef MAXPOOL_SCHED_ABORT_EN
    .abort(1'b0),
`endif
    .busy(s_busy), .done(s_done), .ram_en(s_ram_en), .ram_addr(s_ram_addr),
    .ram_rd(s_ram_rd), .out_data(s_out_data), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_last_win(s_last_win),
    .out_last_frame(s_last_frame)
  );

  always @(posedge clk) if (ram_en) ram_rd <= mem_val(ram_addr);
  always @(posedge clk) if (s_ram_en) s_ram_rd <= mem_val(s_ram_addr);

  task automatic test_reset();
    checks++;
    if ({busy, done, ram_en, out_valid, out_last_win, out_last_frame} !== 6'b0 ||
        ram_addr !== 32'd0 || out_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b en=%b addr=%0d data=%0h valid=%b lw=%b lf=%b, expected all 0",
               busy, done, ram_en, ram_addr, out_data, out_valid, out_last_win, out_last_frame);
    end
    checks++;
    if (s_busy !== 1'b0 || s_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_values_5x5: busy=%b valid=%b, expected 0 0", s_busy, s_out_valid);
    end
  endtask

  // One full 6x6 frame; bp = random backpressure, spam = extra start pulses.
  task automatic run_frame(input bit bp, input bit spam, input string tag);
    int c = 1, hs = 0, dones = 0, nissue = 0, hs_last = -10;
    bit prev_stall = 0;
    logic [7:0] pd = '0;
    logic pw = 0, pf = 0;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    while (c < 600 && !(dones > 0 && c > hs_last + 3)) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== 32'd0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s first_issue: en=%b addr=%0d busy=%b, expected 1 0 1", tag, ram_en, ram_addr, busy);
        end
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (out_valid !== (c == 3)) begin
          errors++;
          $display("FAIL %s valid_latency c=%0d: valid=%b, expected %b", tag, c, out_valid, c == 3);
        end
      end
      if (ram_en === 1'b1) begin
        checks++;
        if (nissue >= 36 || ram_addr !== exp_addr(nissue, 6)) begin
          errors++;
          $display("FAIL %s ram_addr #%0d: got %0d, expected %0d", tag, nissue, ram_addr, exp_addr(nissue, 6));
        end
        nissue++;
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd || out_last_win !== pw || out_last_frame !== pf) begin
          errors++;
          $display("FAIL %s stall_stable: valid=%b data=%0h lw=%b lf=%b, expected 1 %0h %b %b",
                   tag, out_valid, out_data, out_last_win, out_last_frame, pd, pw, pf);
        end
      end
      if (done === 1'b1) begin
        dones++;
        checks++;
        if (c != hs_last + 1 || hs != 36) begin
          errors++;
          $display("FAIL %s done_timing: done at cycle %0d after %0d handshakes, expected cycle %0d after 36",
                   tag, c, hs, hs_last + 1);
        end
        if (spam) start = 1'b1;
      end
      if (hs == 36 && c == hs_last + 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_in_done: busy=%b, expected 1", tag, busy);
        end
      end
      if (hs == 36 && c >= hs_last + 2) begin
        checks++;
        if (busy !== 1'b0 || ram_en !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s idle_after_done c=%0d: busy=%b en=%b done=%b, expected 0 0 0", tag, c, busy, ram_en, done);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (hs >= 36 || out_data !== mem_val(exp_addr(hs, 6)) ||
            out_last_win !== (hs % 4 == 3) || out_last_frame !== (hs == 35)) begin
          errors++;
          $display("FAIL %s element #%0d: data=%0h lw=%b lf=%b, expected %0h %b %b", tag, hs, out_data,
                   out_last_win, out_last_frame, mem_val(exp_addr(hs, 6)), hs % 4 == 3, hs == 35);
        end
        hs++;
        if (hs == 36) hs_last = c;
      end
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      pd = out_data;
      pw = out_last_win;
      pf = out_last_frame;
      @(posedge clk); #1;
      c++;
      start = spam && (c % 3 == 0) && (hs < 36);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    start = 1'b0;
    checks++;
    if (hs != 36 || dones != 1 || nissue != 36) begin
      errors++;
      $display("FAIL %s frame_count: handshakes=%0d dones=%0d reads=%0d, expected 36 1 36", tag, hs, dones, nissue);
    end
    if (!bp) begin
      checks++;
      if (hs_last != 108) begin
        errors++;
        $display("FAIL %s frame_length: last handshake cycle %0d, expected 108", tag, hs_last);
      end
    end
  endtask

  task automatic test_small_map();
    logic [31:0] exp5 [16] = '{0, 1, 5, 6, 2, 3, 7, 8, 10, 11, 15, 16, 12, 13, 17, 18};
    int n = 0, hs = 0, dones = 0, lf = 0;
    @(posedge clk); #1;
    s_start = 1'b1;
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (s_ram_en === 1'b1) begin
        checks++;
        if (n >= 16 || s_ram_addr !== exp5[n] || s_ram_addr % 5 == 4 || s_ram_addr >= 20) begin
          errors++;
          $display("FAIL small_map ram_addr #%0d: got %0d, expected %0d", n, s_ram_addr, n < 16 ? exp5[n] : 0);
        end
        n++;
      end
      if (s_out_valid === 1'b1) begin
        checks++;
        if (hs >= 16 || s_out_data !== mem_val(exp5[hs]) || s_last_win !== (hs % 4 == 3)) begin
          errors++;
          $display("FAIL small_map element #%0d: data=%0h lw=%b, expected %0h %b", hs, s_out_data, s_last_win,
                   mem_val(exp5[hs]), hs % 4 == 3);
        end
        if (s_last_frame === 1'b1) lf++;
        hs++;
      end
      if (s_done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 16 || hs != 16 || dones != 1 || lf != 1 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL small_map counts: reads=%0d elems=%0d dones=%0d last_frame=%0d busy=%b, expected 16 16 1 1 0",
               n, hs, dones, lf, s_busy);
    end
  endtask

  task automatic test_reset_midframe();
    int hs = 0;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200 && hs < 10; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) hs++;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL midframe_no_done: done=%b after %0d handshakes, expected 0", done, hs);
      end
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, ram_en, out_valid, out_last_win, out_last_frame} !== 6'b0 ||
        ram_addr !== 32'd0 || out_data !== 8'd0 || hs != 10) begin
      errors++;
      $display("FAIL midframe_reset: hs=%0d busy=%b done=%b en=%b addr=%0d data=%0h valid=%b, expected 10 and all 0",
               hs, busy, done, ram_en, ram_addr, out_data, out_valid);
    end
    @(negedge clk);
    rstn = 1'b1;
    run_frame(1'b0, 1'b0, "after_reset");
  endtask

`ifdef MAXPOOL_SCHED_ABORT_EN
  task automatic test_abort();
    int c = 0;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    while (out_valid !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b valid=%b done=%b en=%b, expected 0 0 0 0", busy, out_valid, done, ram_en);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done: done=%b busy=%b, expected 0 0", done, busy);
      end
    end
    run_frame(1'b0, 1'b0, "after_abort");
  endtask
`endif

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    s_start = 1'b0;
    s_out_ready = 1'b0;
`ifdef MAXPOOL_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    run_frame(1'b0, 1'b0, "basic");
    run_frame(1'b1, 1'b0, "backpressure");
    test_small_map();
    run_frame(1'b1, 1'b1, "start_spam");
    test_reset_midframe();
`ifdef MAXPOOL_SCHED_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
